// File: rtl/dual_cam_line_sched_pkg.sv
// Shared types and defaults for the dual-OV5640 line scheduler.
package dual_cam_pkg;

  localparam int H_ACT_DEF  = 640;
  localparam int V_ACT_DEF  = 480;
  localparam int OFFSET_DEF = 200;

  typedef enum logic [1:0] {
    MODE_SIDE    = 2'd0,
    MODE_CAM0    = 2'd1,
    MODE_CAM1    = 2'd2,
    MODE_OVERLAP = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LINE,
    ST_RD_A,
    ST_RD_B,
    ST_DROP,
    ST_HBLANK
  } state_t;

endpackage

// File: rtl/dual_cam_line_sched_if.sv
// Read-side bus of the two camera line FIFOs (level, read data, read enable).
interface dual_cam_line_sched_if #(
  parameter int DW    = 16,
  parameter int LVL_W = 12
);
  logic [LVL_W-1:0] fifo0_level;
  logic [LVL_W-1:0] fifo1_level;
  logic [DW-1:0]    fifo0_q;
  logic [DW-1:0]    fifo1_q;
  logic             fifo0_rd_en;
  logic             fifo1_rd_en;

  modport master (
    input  fifo0_level, fifo1_level, fifo0_q, fifo1_q,
    output fifo0_rd_en, fifo1_rd_en
  );

  modport slave (
    output fifo0_level, fifo1_level, fifo0_q, fifo1_q,
    input  fifo0_rd_en, fifo1_rd_en
  );
endinterface

// File: rtl/dual_cam_line_sched_out_pipe.sv
// Two-stage output alignment: stage 1 carries the valid/source tag beside the
// FIFO read, stage 2 captures the selected FIFO word once it is valid.
module dual_cam_out_pipe #(
  parameter int DW = 16
) (
  input  logic          cmos0_pclk,
  input  logic          sys_rst_n,
  input  logic          tag_valid,
  input  logic          tag_sel,
  input  logic [DW-1:0] fifo0_q,
  input  logic [DW-1:0] fifo1_q,
  output logic [DW-1:0] pixel_data,
  output logic          pixel_href
);

  logic s1_valid;
  logic s1_sel;

  // NOTE: registers are written with <= so every stage samples the pre-edge value of the one before it.
  always_ff @(posedge cmos0_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid   <= 1'b0;
      s1_sel     <= 1'b0;
      pixel_href <= 1'b0;
      pixel_data <= '0;
    end else begin
      s1_valid   <= tag_valid;
      s1_sel     <= tag_sel;
      pixel_href <= s1_valid;
      // Blank the bus outside active pixels so the writer never sees stale data.
      pixel_data <= !s1_valid ? '0 : (s1_sel ? fifo1_q : fifo0_q);
    end
  end

endmodule

// File: rtl/dual_cam_line_sched.sv
// Line scheduler: drains the cam0/cam1 line FIFOs into one spliced output line
// per input line pair, with fixed horizontal blanking and a frame line count.
module dual_cam_line_sched
  import dual_cam_pkg::*;
#(
  parameter int DW      = 16,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int OFFSET  = OFFSET_DEF,
  parameter int H_BLANK = 32,
  parameter int LVL_W   = 12
) (
  input  logic                  cmos0_pclk,
  input  logic                  sys_rst_n,
  input  logic                  frame_start,
  input  logic [1:0]            mode,
  dual_cam_line_sched_if.master fifo,
  output logic [DW-1:0]         pixel_data,
  output logic                  pixel_href,
  output logic                  pixel_sync,
  output logic [9:0]            line_cnt,
  output logic                  resync
);

  localparam int CNT_W = 16;

  state_t           state;
  state_t           state_n;
  mode_t            mode_q;
  logic [CNT_W-1:0] px;
  logic [CNT_W-1:0] seg_len;
  logic             seg_done;
  logic             lvl0_ok;
  logic             lvl1_ok;
  logic             line_ready;
  logic             line_inc;

  assign lvl0_ok = fifo.fifo0_level >= LVL_W'(H_ACT);
  assign lvl1_ok = fifo.fifo1_level >= LVL_W'(H_ACT);

  always_comb begin
    case (mode_q)
      MODE_CAM0: line_ready = lvl0_ok;
      MODE_CAM1: line_ready = lvl1_ok;
      default:   line_ready = lvl0_ok && lvl1_ok;
    endcase
  end

  // Length of the segment served by the current state; RD_A is short in OVERLAP.
  always_comb begin
    case (state)
      ST_RD_A:   seg_len = (mode_q == MODE_OVERLAP) ? CNT_W'(OFFSET) : CNT_W'(H_ACT);
      ST_DROP:   seg_len = CNT_W'(H_ACT - OFFSET);
      ST_RD_B:   seg_len = CNT_W'(H_ACT);
      ST_HBLANK: seg_len = CNT_W'(H_BLANK);
      default:   seg_len = '0;
    endcase
  end

  assign seg_done = (px == seg_len - CNT_W'(1));

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    line_inc = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_WAIT_LINE: begin
        if (line_ready) state_n = (mode_q == MODE_CAM0) ? ST_RD_B : ST_RD_A;
      end
      ST_RD_A: begin
        if (seg_done) begin
          if (mode_q == MODE_OVERLAP)   state_n = ST_DROP;
          else if (mode_q == MODE_SIDE) state_n = ST_RD_B;
          else                          state_n = ST_HBLANK;
        end
      end
      ST_DROP: begin
        if (seg_done) state_n = ST_RD_B;
      end
      ST_RD_B: begin
        if (seg_done) state_n = ST_HBLANK;
      end
      ST_HBLANK: begin
        if (seg_done) begin
          line_inc = 1'b1;
          state_n  = ((line_cnt + 10'd1) == 10'(V_ACT)) ? ST_IDLE : ST_WAIT_LINE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A new frame overrides everything, including the last blanking cycle.
    if (frame_start) begin
      state_n  = ST_WAIT_LINE;
      line_inc = 1'b0;
    end
  end

  always_ff @(posedge cmos0_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      px         <= '0;
      mode_q     <= MODE_SIDE;
      line_cnt   <= '0;
      pixel_sync <= 1'b0;
      resync     <= 1'b0;
    end else begin
      state      <= state_n;
      px         <= (state_n != state || frame_start) ? '0 : px + CNT_W'(1);
      pixel_sync <= frame_start;
      if (frame_start) begin
        mode_q   <= mode_t'(mode);
        line_cnt <= '0;
        if (state != ST_IDLE) resync <= 1'b1;
      end else if (line_inc) begin
        line_cnt <= line_cnt + 10'd1;
      end
    end
  end

  // DROP pops cam1 words that fall under the cam0 image; they never reach href.
  assign fifo.fifo1_rd_en = (state == ST_RD_A) || (state == ST_DROP);
  assign fifo.fifo0_rd_en = (state == ST_RD_B);

  dual_cam_out_pipe #(.DW(DW)) u_out_pipe (
    .cmos0_pclk (cmos0_pclk),
    .sys_rst_n  (sys_rst_n),
    .tag_valid  ((state == ST_RD_A) || (state == ST_RD_B)),
    .tag_sel    (state == ST_RD_A),
    .fifo0_q    (fifo.fifo0_q),
    .fifo1_q    (fifo.fifo1_q),
    .pixel_data (pixel_data),
    .pixel_href (pixel_href)
  );

endmodule

// File: tb/tb_dual_cam_line_sched.sv
// Bench for dual_cam_line_sched: random camera data through modelled FIFOs,
// output lines compared against a per-mode splice model.
module tb_dual_cam_line_sched;
  import dual_cam_pkg::*;

  localparam int DW      = 16;
  localparam int H_ACT   = 640;
  localparam int V_ACT   = 4;
  localparam int OFFSET  = 200;
  localparam int H_BLANK = 32;
  localparam int LVL_W   = 12;
  localparam int LIMIT   = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [1:0]    mode_in = 2'd0;
  logic [DW-1:0] pixel_data;
  logic          pixel_href;
  logic          pixel_sync;
  logic [9:0]    line_cnt;
  logic          resync;

  int n_vec = 0;
  int n_bad = 0;

  // Camera data source and FIFO model (write/read word pointers).
  logic [DW-1:0]    tbl0 [4096];
  logic [DW-1:0]    tbl1 [4096];
  int               wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  int               n_rd0 = 0, n_rd1 = 0, underflow = 0;
  bit               fill0 = 1'b0, fill1 = 1'b0, flush_req = 1'b0;
  int               ovr0 = -1, ovr1 = -1;
  logic [LVL_W-1:0] lvl0_r = '0, lvl1_r = '0;
  logic [DW-1:0]    q0_r = '0, q1_r = '0;
  int               e0 = 0, e1 = 0;

  dual_cam_line_sched_if #(.DW(DW), .LVL_W(LVL_W)) fifo_bus ();

  dual_cam_line_sched #(
    .DW(DW), .H_ACT(H_ACT), .V_ACT(V_ACT), .OFFSET(OFFSET), .H_BLANK(H_BLANK), .LVL_W(LVL_W)
  ) dut (
    .cmos0_pclk  (clk),
    .sys_rst_n   (rst_n),
    .frame_start (frame_start),
    .mode        (mode_in),
    .fifo        (fifo_bus),
    .pixel_data  (pixel_data),
    .pixel_href  (pixel_href),
    .pixel_sync  (pixel_sync),
    .line_cnt    (line_cnt),
    .resync      (resync)
  );

  always #5 clk = ~clk;

  assign fifo_bus.fifo0_level = (ovr0 >= 0) ? LVL_W'(ovr0) : lvl0_r;
  assign fifo_bus.fifo1_level = (ovr1 >= 0) ? LVL_W'(ovr1) : lvl1_r;
  assign fifo_bus.fifo0_q     = q0_r;
  assign fifo_bus.fifo1_q     = q1_r;

  always @(posedge clk) begin
    if (flush_req) begin
      rd0 = wr0;
      rd1 = wr1;
    end else begin
      if (fifo_bus.fifo0_rd_en) begin
        if (rd0 == wr0) underflow++;
        q0_r <= tbl0[rd0 % 4096];
        rd0++;
        n_rd0++;
      end
      if (fifo_bus.fifo1_rd_en) begin
        if (rd1 == wr1) underflow++;
        q1_r <= tbl1[rd1 % 4096];
        rd1++;
        n_rd1++;
      end
    end
    if (fill0 && (wr0 - rd0) < H_ACT) wr0 += H_ACT;
    if (fill1 && (wr1 - rd1) < H_ACT) wr1 += H_ACT;
    lvl0_r <= ((wr0 - rd0) > 4095) ? 12'hFFF : LVL_W'(wr0 - rd0);
    lvl1_r <= ((wr1 - rd1) > 4095) ? 12'hFFF : LVL_W'(wr1 - rd1);
  end

  function automatic logic [DW-1:0] word(input int cam, input int idx);
    return (cam == 1) ? tbl1[idx % 4096] : tbl0[idx % 4096];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flush();
    fill0 = 1'b0;
    fill1 = 1'b0;
    flush_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush_req = 1'b0;
    e0 = wr0;
    e1 = wr1;
  endtask

  task automatic count_activity(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      cnt += int'(fifo_bus.fifo0_rd_en | fifo_bus.fifo1_rd_en | pixel_href);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},   32'(pixel_data), 0);
    check({tag, "_href"},   32'(pixel_href), 0);
    check({tag, "_sync"},   32'(pixel_sync), 0);
    check({tag, "_line"},   32'(line_cnt), 0);
    check({tag, "_resync"}, 32'(resync), 0);
    check({tag, "_rd0"},    32'(fifo_bus.fifo0_rd_en), 0);
    check({tag, "_rd1"},    32'(fifo_bus.fifo1_rd_en), 0);
  endtask

  task automatic pulse_frame(input mode_t m, input logic exp_resync);
    @(negedge clk);
    mode_in = m;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    mode_in = 2'($urandom_range(0, 3));
    check("sync_pulse", 32'(pixel_sync), 1);
    check("line_clear", 32'(line_cnt), 0);
    check("resync_state", 32'(resync), 32'(exp_resync));
    @(negedge clk);
    check("sync_fall", 32'(pixel_sync), 0);
  endtask

  // Expected line = (href, data) per cycle from the href rise through the first
  // cycle after the line, built from the per-mode splice rules.
  task automatic check_line(input mode_t m, input int idx, input int exp_gap);
    logic [DW:0] exp[$];
    logic [DW:0] got, fg, fe;
    int waited, bad, first;
    case (m)
      MODE_SIDE: begin
        for (int i = 0; i < H_ACT; i++) begin exp.push_back({1'b1, word(1, e1)}); e1++; end
        for (int i = 0; i < H_ACT; i++) begin exp.push_back({1'b1, word(0, e0)}); e0++; end
      end
      MODE_CAM0: begin
        for (int i = 0; i < H_ACT; i++) begin exp.push_back({1'b1, word(0, e0)}); e0++; end
      end
      MODE_CAM1: begin
        for (int i = 0; i < H_ACT; i++) begin exp.push_back({1'b1, word(1, e1)}); e1++; end
      end
      default: begin
        for (int i = 0; i < OFFSET; i++) begin exp.push_back({1'b1, word(1, e1)}); e1++; end
        e1 += H_ACT - OFFSET;
        for (int i = 0; i < H_ACT - OFFSET; i++) exp.push_back('0);
        for (int i = 0; i < H_ACT; i++) begin exp.push_back({1'b1, word(0, e0)}); e0++; end
      end
    endcase
    exp.push_back('0);
    waited = 0;
    while (pixel_href !== 1'b1 && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    check("href_rise", 32'(pixel_href), 1);
    if (pixel_href !== 1'b1) return;
    if (exp_gap > 0) check("line_gap", 32'(waited), 32'(exp_gap));
    check("line_index", 32'(line_cnt), 32'(idx));
    bad = 0;
    first = -1;
    fg = '0;
    fe = '0;
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) @(negedge clk);
      got = {pixel_href, pixel_data};
      if (got !== exp[i]) begin
        if (bad == 0) begin first = i; fg = got; fe = exp[i]; end
        bad++;
      end
    end
    n_vec++;
    assert (bad == 0) else begin
      n_bad++;
      $error("FAIL line_data[%0d]: %0d bad cycles, first at %0d observed %h expected %h",
             idx, bad, first, fg, fe);
    end
  endtask

  task automatic frame_tail(input mode_t m, input int s0, input int s1);
    int act;
    repeat (H_BLANK + 4) @(negedge clk);
    check("end_line_cnt", 32'(line_cnt), V_ACT);
    count_activity(64, act);
    check("idle_after_frame", 32'(act), 0);
    check("cam0_reads", 32'(n_rd0 - s0), (m == MODE_CAM1) ? 0 : V_ACT * H_ACT);
    check("cam1_reads", 32'(n_rd1 - s1), (m == MODE_CAM0) ? 0 : V_ACT * H_ACT);
  endtask

  task automatic run_frame(input mode_t m, input logic exp_resync);
    int s0, s1;
    s0 = n_rd0;
    s1 = n_rd1;
    pulse_frame(m, exp_resync);
    for (int l = 0; l < V_ACT; l++) check_line(m, l, (l == 0) ? 0 : H_BLANK + 1);
    frame_tail(m, s0, s1);
  endtask

  initial begin
    int act, waited, s0, s1, e1_line;
    mode_t m;
    for (int i = 0; i < 4096; i++) begin
      tbl0[i] = DW'($urandom);
      tbl1[i] = DW'($urandom);
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    fill0 = 1'b1;
    fill1 = 1'b1;
    count_activity(50, act);
    check("no_activity_before_frame", 32'(act), 0);

    run_frame(MODE_SIDE, 1'b0);

    flush();
    fill0 = 1'b1; fill1 = 1'b1;
    run_frame(MODE_OVERLAP, 1'b0);

    flush();
    fill0 = 1'b1;
    run_frame(MODE_CAM0, 1'b0);

    flush();
    fill1 = 1'b1;
    run_frame(MODE_CAM1, 1'b0);

    // cam0 one word short: the line must not start until it is complete.
    flush();
    ovr0 = H_ACT - 1;
    fill0 = 1'b1; fill1 = 1'b1;
    pulse_frame(MODE_SIDE, 1'b0);
    count_activity(20, act);
    check("stall_no_reads", 32'(act), 0);
    ovr0 = -1;
    @(negedge clk);
    check("first_read_after_level", 32'(fifo_bus.fifo1_rd_en), 1);
    check("href_low_1", 32'(pixel_href), 0);
    @(negedge clk);
    check("href_low_2", 32'(pixel_href), 0);
    @(negedge clk);
    check("href_rise_after_2", 32'(pixel_href), 1);
    for (int l = 0; l < 3; l++) check_line(MODE_SIDE, l, (l == 0) ? 0 : H_BLANK + 1);

    // Abort line 3 at px=300 with a new frame in CAM1.
    waited = 0;
    while (fifo_bus.fifo1_rd_en !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("line3_start", 32'(fifo_bus.fifo1_rd_en), 1);
    e1_line = e1;
    repeat (300) @(negedge clk);
    ovr0 = 0;
    ovr1 = 0;
    mode_in = MODE_CAM1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    mode_in = 2'($urandom_range(0, 3));
    check("abort_sync", 32'(pixel_sync), 1);
    check("abort_resync", 32'(resync), 1);
    check("abort_line_cnt", 32'(line_cnt), 0);
    check("abort_rd1_stops", 32'(fifo_bus.fifo1_rd_en), 0);
    check("abort_drain_href", 32'(pixel_href), 1);
    @(negedge clk);
    check("abort_drain_last", {15'd0, pixel_href, pixel_data}, {15'd0, 1'b1, word(1, e1_line + 300)});
    @(negedge clk);
    check("abort_drain_done", {15'd0, pixel_href, pixel_data}, 0);
    flush();
    s0 = n_rd0;
    s1 = n_rd1;
    ovr0 = -1;
    ovr1 = -1;
    fill0 = 1'b1; fill1 = 1'b1;
    for (int l = 0; l < V_ACT; l++) check_line(MODE_CAM1, l, (l == 0) ? 0 : H_BLANK + 1);
    frame_tail(MODE_CAM1, s0, s1);
    check("resync_sticky", 32'(resync), 1);

    // Reset in the middle of a cam0 read.
    flush();
    fill0 = 1'b1;
    pulse_frame(MODE_CAM0, 1'b1);
    waited = 0;
    while (fifo_bus.fifo0_rd_en !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (100) @(negedge clk);
    check("rd_b_active", 32'(fifo_bus.fifo0_rd_en), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    fill1 = 1'b1;
    count_activity(100, act);
    check("no_activity_after_reset", 32'(act), 0);

    flush();
    fill0 = 1'b1; fill1 = 1'b1;
    m = mode_t'($urandom_range(0, 3));
    run_frame(m, 1'b0);

    check("fifo_underflow", 32'(underflow), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
